// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bus: ID/EX/MEM hazard inputs plus the pipeline control
// and statistics outputs. The controller connects through the slave modport.
interface pipeline_hazard_ctrl_if #(
    parameter int REG_ADDR_W = 3
);
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic                  id_uses_rs;
    logic                  id_uses_rt;
    logic                  ex_MemRead;
    logic                  ex_RegWrite;
    logic [REG_ADDR_W-1:0] ex_write_reg;
    logic                  ex_branch_taken;
    logic                  dmem_req;
    logic                  dmem_ready;
    logic                  pc_write;
    logic                  ifid_write;
    logic                  ifid_flush;
    logic                  idex_bubble;
    logic                  pipe_hold;
    logic [15:0]           stall_cycles;
    logic [15:0]           flush_count;
    logic                  mem_timeout;

    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt,
        output ex_MemRead, ex_RegWrite, ex_write_reg, ex_branch_taken,
        output dmem_req, dmem_ready,
        input  pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold,
        input  stall_cycles, flush_count, mem_timeout
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt,
        input  ex_MemRead, ex_RegWrite, ex_write_reg, ex_branch_taken,
        input  dmem_req, dmem_ready,
        output pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold,
        output stall_cycles, flush_count, mem_timeout
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 16-bit MIPS pipeline. Resolves load-use
// hazards, taken-branch squashes and multi-cycle data-memory waits, and keeps
// saturating stall/flush statistics plus a sticky memory-timeout flag.
// Control outputs are combinational from state and current inputs.
module pipeline_hazard_ctrl #(
    parameter int REG_ADDR_W      = 3,
    parameter int LOAD_USE_CYCLES = 1,
    parameter int MEM_TIMEOUT     = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pipeline_hazard_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LU_STALL = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_e;

    localparam logic [3:0]  LU_INIT_C  = 4'(LOAD_USE_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_C  = 16'(MEM_TIMEOUT);

    // Saturating 16-bit increment shared by all counters.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            return v;
        end else begin
            return v + 16'd1;
        end
    endfunction

    state_e      state_r, saved_r;
    logic [3:0]  lu_cnt_r;
    logic [15:0] wait_cnt_r, stall_cycles_r, flush_count_r;
    logic        mem_timeout_r;

    state_e      eff_state_s, state_nx_s, saved_nx_s;
    logic [3:0]  lu_cnt_nx_s;
    logic [15:0] wait_cnt_nx_s;
    logic        lu_hazard_s, mem_stall_s, release_s, flush_inc_s, mem_timeout_nx_s;
    logic        pc_write_s, ifid_write_s, ifid_flush_s, idex_bubble_s, pipe_hold_s;

    // Hazard detection, output decode and next-state selection.
    always_comb begin
        lu_hazard_s = bus.ex_MemRead & bus.ex_RegWrite &
                      (bus.ex_write_reg != {REG_ADDR_W{1'b0}}) &
                      ((bus.id_uses_rs & (bus.id_rs == bus.ex_write_reg)) |
                       (bus.id_uses_rt & (bus.id_rt == bus.ex_write_reg)));
        mem_stall_s = bus.dmem_req & ~bus.dmem_ready;
        // A completing memory access replays the state that was interrupted.
        release_s   = (state_r == ST_MEM_WAIT) & bus.dmem_ready;
        eff_state_s = release_s ? saved_r : state_r;

        pc_write_s    = 1'b1;
        ifid_write_s  = 1'b1;
        ifid_flush_s  = 1'b0;
        idex_bubble_s = 1'b0;
        pipe_hold_s   = 1'b0;
        state_nx_s    = eff_state_s;
        saved_nx_s    = saved_r;
        lu_cnt_nx_s   = lu_cnt_r;
        wait_cnt_nx_s = release_s ? 16'd0 : wait_cnt_r;
        flush_inc_s   = 1'b0;

        case (eff_state_s)
            ST_RUN: begin
                if (mem_stall_s) begin
                    pc_write_s    = 1'b0;
                    ifid_write_s  = 1'b0;
                    pipe_hold_s   = 1'b1;
                    saved_nx_s    = ST_RUN;
                    state_nx_s    = ST_MEM_WAIT;
                    wait_cnt_nx_s = 16'd1;
                end else if (bus.ex_branch_taken) begin
                    // The ID instruction is squashed, so a coincident hazard is moot.
                    ifid_flush_s  = 1'b1;
                    idex_bubble_s = 1'b1;
                    flush_inc_s   = 1'b1;
                end else if (lu_hazard_s) begin
                    pc_write_s    = 1'b0;
                    ifid_write_s  = 1'b0;
                    idex_bubble_s = 1'b1;
                    if (LOAD_USE_CYCLES > 1) begin
                        state_nx_s  = ST_LU_STALL;
                        lu_cnt_nx_s = LU_INIT_C;
                    end else begin
                        state_nx_s  = ST_RUN;
                    end
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            ST_LU_STALL: begin
                pc_write_s   = 1'b0;
                ifid_write_s = 1'b0;
                if (mem_stall_s) begin
                    // Countdown frozen; resumes when memory completes.
                    pipe_hold_s   = 1'b1;
                    saved_nx_s    = ST_LU_STALL;
                    state_nx_s    = ST_MEM_WAIT;
                    wait_cnt_nx_s = 16'd1;
                end else begin
                    idex_bubble_s = 1'b1;
                    lu_cnt_nx_s   = lu_cnt_r - 4'd1;
                    if (lu_cnt_r == 4'd1) begin
                        state_nx_s = ST_RUN;
                    end else begin
                        state_nx_s = ST_LU_STALL;
                    end
                end
            end
            ST_MEM_WAIT: begin
                pc_write_s    = 1'b0;
                ifid_write_s  = 1'b0;
                pipe_hold_s   = 1'b1;
                wait_cnt_nx_s = sat_inc16(wait_cnt_r);
            end
            default: begin
                state_nx_s = ST_RUN;
            end
        endcase

        mem_timeout_nx_s = mem_timeout_r | (wait_cnt_nx_s >= TIMEOUT_C);
    end

    // Drive pipeline controls, forcing the safe NOP pattern while in reset.
    always_comb begin
        if (!rst_n) begin
            bus.pc_write    = 1'b0;
            bus.ifid_write  = 1'b0;
            bus.ifid_flush  = 1'b1;
            bus.idex_bubble = 1'b1;
            bus.pipe_hold   = 1'b0;
        end else begin
            bus.pc_write    = pc_write_s;
            bus.ifid_write  = ifid_write_s;
            bus.ifid_flush  = ifid_flush_s;
            bus.idex_bubble = idex_bubble_s;
            bus.pipe_hold   = pipe_hold_s;
        end
    end

    // State, wait/countdown counters, statistics and sticky timeout flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= ST_RUN;
            saved_r        <= ST_RUN;
            lu_cnt_r       <= 4'd0;
            wait_cnt_r     <= 16'd0;
            stall_cycles_r <= 16'd0;
            flush_count_r  <= 16'd0;
            mem_timeout_r  <= 1'b0;
        end else begin
            state_r       <= state_nx_s;
            saved_r       <= saved_nx_s;
            lu_cnt_r      <= lu_cnt_nx_s;
            wait_cnt_r    <= wait_cnt_nx_s;
            mem_timeout_r <= mem_timeout_nx_s;
            if (!pc_write_s) begin
                stall_cycles_r <= sat_inc16(stall_cycles_r);
            end else begin
                stall_cycles_r <= stall_cycles_r;
            end
            if (flush_inc_s) begin
                flush_count_r <= sat_inc16(flush_count_r);
            end else begin
                flush_count_r <= flush_count_r;
            end
        end
    end

    assign bus.stall_cycles = stall_cycles_r;
    assign bus.flush_count  = flush_count_r;
    assign bus.mem_timeout  = mem_timeout_r;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized and directed bench for pipeline_hazard_ctrl, checked every cycle
// against a behavioural model that tracks remaining stall cycles and an
// outstanding memory wait rather than controller states.
module tb_pipeline_hazard_ctrl;

    localparam int LU_C = 2;
    localparam int TO_C = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;

    pipeline_hazard_ctrl_if #(.REG_ADDR_W(3)) bus ();

    pipeline_hazard_ctrl #(
        .REG_ADDR_W(3), .LOAD_USE_CYCLES(LU_C), .MEM_TIMEOUT(TO_C)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;

    // Model state.
    int m_lu_left = 0, m_wait_n = 0, m_stalls = 0, m_flushes = 0;
    bit m_waiting = 0, m_timeout = 0;
    // Model next state and expected controls for the current cycle.
    int n_lu_left, n_wait_n, n_stalls, n_flushes;
    bit n_waiting, n_timeout;
    bit e_pc, e_ifw, e_fl, e_bub, e_hold;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic int sat16(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    task automatic model_eval();
        bit hz;
        e_pc = 1; e_ifw = 1; e_fl = 0; e_bub = 0; e_hold = 0;
        n_lu_left = m_lu_left; n_wait_n = m_wait_n; n_stalls = m_stalls;
        n_flushes = m_flushes; n_waiting = m_waiting; n_timeout = m_timeout;
        if (!rst_n) begin
            e_pc = 0; e_ifw = 0; e_fl = 1; e_bub = 1;
            n_lu_left = 0; n_wait_n = 0; n_stalls = 0; n_flushes = 0;
            n_waiting = 0; n_timeout = 0;
        end else begin
            hz = bus.ex_MemRead && bus.ex_RegWrite && (bus.ex_write_reg != 0) &&
                 ((bus.id_uses_rs && bus.id_rs == bus.ex_write_reg) ||
                  (bus.id_uses_rt && bus.id_rt == bus.ex_write_reg));
            if (m_waiting && !bus.dmem_ready) begin
                e_pc = 0; e_ifw = 0; e_hold = 1;
                n_wait_n = sat16(m_wait_n);
            end else begin
                n_waiting = 0; n_wait_n = 0;
                if (bus.dmem_req && !bus.dmem_ready) begin
                    e_pc = 0; e_ifw = 0; e_hold = 1;
                    n_waiting = 1; n_wait_n = 1;
                end else if (m_lu_left > 0) begin
                    e_pc = 0; e_ifw = 0; e_bub = 1;
                    n_lu_left = m_lu_left - 1;
                end else if (bus.ex_branch_taken) begin
                    e_fl = 1; e_bub = 1;
                    n_flushes = sat16(m_flushes);
                end else if (hz) begin
                    e_pc = 0; e_ifw = 0; e_bub = 1;
                    n_lu_left = LU_C - 1;
                end
            end
            if (n_wait_n >= TO_C) n_timeout = 1;
            if (!e_pc) n_stalls = sat16(m_stalls);
        end
    endtask

    // Inputs are already set; check controls, clock once, check registers.
    task automatic run_cycle();
        #1;
        model_eval();
        check_val("pc_write", bus.pc_write, e_pc);
        check_val("ifid_write", bus.ifid_write, e_ifw);
        check_val("ifid_flush", bus.ifid_flush, e_fl);
        check_val("idex_bubble", bus.idex_bubble, e_bub);
        check_val("pipe_hold", bus.pipe_hold, e_hold);
        @(posedge clk);
        m_lu_left = n_lu_left; m_wait_n = n_wait_n; m_stalls = n_stalls;
        m_flushes = n_flushes; m_waiting = n_waiting; m_timeout = n_timeout;
        #1;
        check_val("stall_cycles", bus.stall_cycles, m_stalls[15:0]);
        check_val("flush_count", bus.flush_count, m_flushes[15:0]);
        check_val("mem_timeout", bus.mem_timeout, m_timeout);
    endtask

    task automatic set_idle();
        bus.id_rs = 3'd0; bus.id_rt = 3'd0; bus.id_uses_rs = 1'b0; bus.id_uses_rt = 1'b0;
        bus.ex_MemRead = 1'b0; bus.ex_RegWrite = 1'b0; bus.ex_write_reg = 3'd0;
        bus.ex_branch_taken = 1'b0; bus.dmem_req = 1'b0; bus.dmem_ready = 1'b0;
    endtask

    task automatic set_load(input logic [2:0] wr);
        bus.ex_MemRead = 1'b1; bus.ex_RegWrite = 1'b1; bus.ex_write_reg = wr;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; set_idle();
        run_cycle(); run_cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [15:0] s0;
        set_idle();
        @(posedge clk); #1;
        check_val("rst_pc_write", bus.pc_write, 1'b0);
        check_val("rst_ifid_flush", bus.ifid_flush, 1'b1);
        check_val("rst_idex_bubble", bus.idex_bubble, 1'b1);
        do_reset();
        run_cycle();
        check_val("post_rst_pc_write", bus.pc_write, 1'b1);

        // Load-use on rs: two stall cycles then release.
        s0 = bus.stall_cycles;
        set_load(3'd3); bus.id_rs = 3'd3; bus.id_uses_rs = 1'b1;
        run_cycle();
        set_idle(); #1;
        check_val("lu_second_stall", bus.pc_write, 1'b0);
        run_cycle();
        #1; check_val("lu_release", bus.pc_write, 1'b1);
        check_val("lu_stall_delta", 32'(bus.stall_cycles - s0), 32'd2);
        run_cycle();

        // r0 destination and unused rt never stall.
        set_load(3'd0); bus.id_rs = 3'd0; bus.id_uses_rs = 1'b1;
        #1; check_val("r0_no_stall", bus.pc_write, 1'b1);
        run_cycle();
        set_idle(); set_load(3'd5); bus.id_rt = 3'd5; bus.id_uses_rt = 1'b0;
        #1; check_val("unused_rt_no_stall", bus.pc_write, 1'b1);
        run_cycle();

        // Taken branch beats a simultaneous load-use hazard.
        s0 = bus.stall_cycles;
        set_idle(); set_load(3'd4); bus.id_rt = 3'd4; bus.id_uses_rt = 1'b1;
        bus.ex_branch_taken = 1'b1;
        #1; check_val("br_flush", bus.ifid_flush, 1'b1);
        check_val("br_pc_write", bus.pc_write, 1'b1);
        run_cycle();
        check_val("br_flush_count", bus.flush_count, 16'd1);
        check_val("br_stall_delta", 32'(bus.stall_cycles - s0), 32'd0);
        set_idle(); run_cycle();

        // Memory wait interrupting the last load-use stall cycle.
        set_load(3'd2); bus.id_rs = 3'd2; bus.id_uses_rs = 1'b1;
        run_cycle();
        s0 = bus.stall_cycles;
        set_idle(); bus.dmem_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1; check_val("mw_pipe_hold", bus.pipe_hold, 1'b1);
            run_cycle();
        end
        bus.dmem_ready = 1'b1;
        #1; check_val("mw_lu_replay_bubble", bus.idex_bubble, 1'b1);
        check_val("mw_lu_replay_pc", bus.pc_write, 1'b0);
        run_cycle();
        set_idle(); #1;
        check_val("mw_back_to_run", bus.pc_write, 1'b1);
        check_val("mw_stall_delta", 32'(bus.stall_cycles - s0), 32'd6);
        run_cycle();

        // Asynchronous reset in the middle of a load-use stall.
        set_load(3'd6); bus.id_rt = 3'd6; bus.id_uses_rt = 1'b1;
        run_cycle();
        set_idle(); #2;
        rst_n = 1'b0; #1;
        check_val("mid_rst_pc_write", bus.pc_write, 1'b0);
        check_val("mid_rst_flush", bus.ifid_flush, 1'b1);
        check_val("mid_rst_bubble", bus.idex_bubble, 1'b1);
        run_cycle();
        rst_n = 1'b1;
        run_cycle();
        check_val("mid_rst_counters", {bus.stall_cycles, bus.flush_count}, 32'd0);

        // Timeout after four wait cycles, sticky after ready.
        bus.dmem_req = 1'b1;
        for (int i = 0; i < 3; i++) run_cycle();
        check_val("to_not_yet", bus.mem_timeout, 1'b0);
        run_cycle();
        check_val("to_set", bus.mem_timeout, 1'b1);
        run_cycle(); run_cycle();
        bus.dmem_ready = 1'b1;
        run_cycle();
        set_idle(); run_cycle();
        check_val("to_sticky", bus.mem_timeout, 1'b1);

        // Randomized traffic, with one reset pulse part way through.
        for (int c = 0; c < 1500; c++) begin
            if (c == 700) begin
                do_reset();
            end
            bus.ex_write_reg    = 3'($urandom_range(0, 7));
            bus.id_rs           = ($urandom_range(0, 1) == 0) ? bus.ex_write_reg : 3'($urandom_range(0, 7));
            bus.id_rt           = ($urandom_range(0, 1) == 0) ? bus.ex_write_reg : 3'($urandom_range(0, 7));
            bus.id_uses_rs      = 1'($urandom_range(0, 1));
            bus.id_uses_rt      = 1'($urandom_range(0, 1));
            bus.ex_MemRead      = ($urandom_range(0, 2) != 0);
            bus.ex_RegWrite     = ($urandom_range(0, 3) != 0);
            bus.ex_branch_taken = ($urandom_range(0, 6) == 0);
            bus.dmem_req        = ($urandom_range(0, 3) == 0);
            bus.dmem_ready      = ($urandom_range(0, 2) == 0);
            run_cycle();
        end

        // Flush counter saturation.
        do_reset();
        set_idle(); bus.ex_branch_taken = 1'b1;
        for (int c = 0; c < 65537; c++) run_cycle();
        check_val("flush_saturated", bus.flush_count, 16'hFFFF);
        set_idle(); run_cycle();
        check_val("flush_stays_sat", bus.flush_count, 16'hFFFF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
